alu_ir_mar_datapath: RTL and testbench
======================================

Name: alu_ir_mar_datapath

Overview:
- Datapath core of the multicycle ARM-style CPU.
- Contains a combinational 32-bit ALU with NZCV flags, plus two 32-bit load-enabled registers.
- IR latches the instruction word from memory data-out.
- MAR latches the ALU result as the memory address.
- Sits between the register file / operand muxes and the ram256x8 memory; driven by the control unit's load strobes and 5-bit ALU opcode.

Parameters:
- WIDTH, 32, datapath width of ALU operands, IR and MAR.

Ports:
- CLK  input  1  system clock, rising-edge active
- CLR  input  1  asynchronous active-high reset
- a  input  WIDTH  ALU operand A (register-file port PA)
- b  input  WIDTH  ALU operand B (operand-B mux output)
- op  input  5  ALU operation select
- cin  input  1  carry-in (current C flag)
- ir_ld  input  1  IR load enable
- ir_d  input  WIDTH  IR data in (memory data-out)
- mar_ld  input  1  MAR load enable
- result  output  WIDTH  ALU result, combinational
- flag_z  output  1  zero flag, combinational
- flag_n  output  1  negative flag, combinational
- flag_c  output  1  carry flag, combinational
- flag_v  output  1  overflow flag, combinational
- ir_q  output  WIDTH  IR contents
- mar_q  output  WIDTH  MAR contents (memory address)

Behaviour:
- One clock (CLK); reset CLR is asynchronous and active-high.
- Reset: while CLR=1, ir_q=0 and mar_q=0 immediately, independent of CLK; loads are ignored.
- IR: on CLK rising edge with CLR=0 and ir_ld=1, ir_q <= ir_d; otherwise it holds. One-cycle latency.
- MAR: on CLK rising edge with CLR=0 and mar_ld=1, mar_q <= result, i.e. the ALU output of the same cycle; otherwise it holds.
- ir_ld and mar_ld are independent; both may load on the same edge.
- ALU is purely combinational; result and flags follow the inputs with no clock.
- ALU opcodes (op):
  - 00000 AND: a&b
  - 00001 EOR: a^b
  - 00010 SUB: a-b
  - 00011 RSB: b-a
  - 00100 ADD: a+b
  - 00101 ADC: a+b+cin
  - 00110 SBC: a-b-!cin
  - 00111 RSC: b-a-!cin
  - 01000 TST: a&b
  - 01001 TEQ: a^b
  - 01010 CMP: a-b
  - 01011 CMN: a+b
  - 01100 ORR: a|b
  - 01101 MOV: b
  - 01110 BIC: a&~b
  - 01111 MVN: ~b
  - 10000: a+4
  - 10001: b+4
  - 10010: pass a
  - 10011: pass b
  - 10100: a+b+4
  - 10101 to 11111: result=0, flags as for a logical op.
- TST/TEQ/CMP/CMN drive result with the computed value; the control unit decides whether to write it back.
- Arithmetic ops compute on WIDTH+1 bits.
  - Addition: C = carry out of bit WIDTH-1.
  - Subtraction: C = NOT borrow (ARM convention), so C=1 when no borrow. Subtraction is implemented as x + ~y + 1 (with cin substituted for the +1 in SBC/RSC).
  - V = signed overflow: operands of equal sign (after inverting y for subtraction) give a result of opposite sign.
- Logical and pass ops: C = cin, V = 0.
- All ops: N = result[WIDTH-1]; Z = (result == 0).
- Wrap-around: results are truncated to WIDTH bits; overflow is reported only via C/V.
- Reset mid-operation: asserting CLR between edges clears IR/MAR at once. Deasserting it resumes normal loads at the next rising edge. The ALU is unaffected by CLR.

Test Plan:
- Reset: CLR=1 with ir_ld=mar_ld=1 and ir_d=0xE3A05005 -> ir_q=0, mar_q=0 across edges. Release CLR, next edge -> ir_q=0xE3A05005.
- ADD overflow: a=0x7FFFFFFF, b=1, op=00100 -> result=0x80000000, N=1, Z=0, C=0, V=1. Then a=0xFFFFFFFF, b=1 -> result=0, Z=1, C=1, V=0.
- SUB/CMP: a=5, b=5, op=01010 -> result=0, Z=1, C=1, V=0. Then a=3, b=5, op=00010 -> result=0xFFFFFFFE, N=1, C=0.
- Carry ops: a=1, b=1, cin=1, op=00101 -> result=3. Then a=1, b=1, cin=0, op=00110 -> result=0xFFFFFFFF, C=0.
- Logical: a=0xF0F0F0F0, b=0xFF00FF00, cin=1, op=01110 -> result=0x00F000F0, C=1, V=0. Then op=01111 -> result=0x00FF00FF.
- MAR/IR load: a=0x100, op=10000, mar_ld=1 at edge -> mar_q=0x104. With mar_ld=0 and a changed -> mar_q holds 0x104. ir_ld=0 -> ir_q holds its value.

Source files
------------

// File: rtl/alu_ir_mar_datapath.sv
// Multicycle CPU datapath core: combinational NZCV ALU feeding a MAR, plus an
// instruction register loaded from memory data-out. Both registers clear asynchronously.
module alu_ir_mar_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       op,
  input  logic             cin,
  input  logic             ir_ld,
  input  logic [WIDTH-1:0] ir_d,
  input  logic             mar_ld,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic [WIDTH-1:0] ir_q,
  output logic [WIDTH-1:0] mar_q
);

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_EOR  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_RSB  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADC  = 5'b00101;
  localparam logic [4:0] OP_SBC  = 5'b00110;
  localparam logic [4:0] OP_RSC  = 5'b00111;
  localparam logic [4:0] OP_TST  = 5'b01000;
  localparam logic [4:0] OP_TEQ  = 5'b01001;
  localparam logic [4:0] OP_CMP  = 5'b01010;
  localparam logic [4:0] OP_CMN  = 5'b01011;
  localparam logic [4:0] OP_ORR  = 5'b01100;
  localparam logic [4:0] OP_MOV  = 5'b01101;
  localparam logic [4:0] OP_BIC  = 5'b01110;
  localparam logic [4:0] OP_MVN  = 5'b01111;
  localparam logic [4:0] OP_A4   = 5'b10000;
  localparam logic [4:0] OP_B4   = 5'b10001;
  localparam logic [4:0] OP_PA   = 5'b10010;
  localparam logic [4:0] OP_PB   = 5'b10011;
  localparam logic [4:0] OP_AB4  = 5'b10100;

  localparam logic [WIDTH:0] K_ZERO = '0;
  localparam logic [WIDTH:0] K_ONE  = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] K_FOUR = (WIDTH+1)'(4);

  // Every arithmetic op is reduced to x + y + k on a single WIDTH+1 bit adder;
  // subtraction arrives here with y already inverted so V can be judged on x/y.
  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic [WIDTH:0]   add_k;
  logic [WIDTH:0]   add_sum;
  logic             is_arith;
  logic [WIDTH-1:0] logic_res;
  logic [WIDTH-1:0] ir_reg;
  logic [WIDTH-1:0] mar_reg;

  always_comb begin
    add_x     = '0;
    add_y     = '0;
    add_k     = K_ZERO;
    is_arith  = 1'b0;
    logic_res = '0;
    case (op)
      OP_AND, OP_TST: logic_res = a & b;
      OP_EOR, OP_TEQ: logic_res = a ^ b;
      OP_ORR:         logic_res = a | b;
      OP_MOV, OP_PB:  logic_res = b;
      OP_BIC:         logic_res = a & ~b;
      OP_MVN:         logic_res = ~b;
      OP_PA:          logic_res = a;
      OP_SUB, OP_CMP: begin
        is_arith = 1'b1;
        add_x    = a;
        add_y    = ~b;
        add_k    = K_ONE;
      end
      OP_RSB: begin
        is_arith = 1'b1;
        add_x    = b;
        add_y    = ~a;
        add_k    = K_ONE;
      end
      OP_ADD, OP_CMN: begin
        is_arith = 1'b1;
        add_x    = a;
        add_y    = b;
      end
      OP_ADC: begin
        is_arith = 1'b1;
        add_x    = a;
        add_y    = b;
        add_k    = {{WIDTH{1'b0}}, cin};
      end
      OP_SBC: begin
        is_arith = 1'b1;
        add_x    = a;
        add_y    = ~b;
        add_k    = {{WIDTH{1'b0}}, cin};
      end
      OP_RSC: begin
        is_arith = 1'b1;
        add_x    = b;
        add_y    = ~a;
        add_k    = {{WIDTH{1'b0}}, cin};
      end
      OP_A4: begin
        is_arith = 1'b1;
        add_x    = a;
        add_y    = K_FOUR[WIDTH-1:0];
      end
      OP_B4: begin
        is_arith = 1'b1;
        add_x    = b;
        add_y    = K_FOUR[WIDTH-1:0];
      end
      OP_AB4: begin
        is_arith = 1'b1;
        add_x    = a;
        add_y    = b;
        add_k    = K_FOUR;
      end
      default: logic_res = '0;
    endcase
  end

  assign add_sum = {1'b0, add_x} + {1'b0, add_y} + add_k;

  always_comb begin
    result = is_arith ? add_sum[WIDTH-1:0] : logic_res;
    flag_n = result[WIDTH-1];
    flag_z = (result == '0);
    flag_c = is_arith ? add_sum[WIDTH] : cin;
    flag_v = is_arith && (add_x[WIDTH-1] == add_y[WIDTH-1])
                      && (result[WIDTH-1] != add_x[WIDTH-1]);
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      ir_reg <= '0;
    end else if (ir_ld) begin
      ir_reg <= ir_d;
    end
  end

  // MAR captures the same-cycle ALU output, giving the address for the next memory access.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      mar_reg <= '0;
    end else if (mar_ld) begin
      mar_reg <= result;
    end
  end

  assign ir_q  = ir_reg;
  assign mar_q = mar_reg;

endmodule

// File: tb/tb_alu_ir_mar_datapath.sv
// Scoreboard bench: driver pushes expected outputs from an arithmetic reference model,
// a negedge monitor pops and compares them against the datapath.
module tb_alu_ir_mar_datapath;

  typedef struct {
    logic        clr;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        ir_ld;
    logic [31:0] ir_d;
    logic        mar_ld;
  } stim_t;

  typedef struct {
    int          id;
    logic [31:0] result;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
    logic [31:0] ir;
    logic [31:0] mar;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  op = '0;
  logic        cin = 1'b0;
  logic        ir_ld = 1'b0;
  logic [31:0] ir_d = '0;
  logic        mar_ld = 1'b0;
  logic [31:0] result;
  logic        flag_z, flag_n, flag_c, flag_v;
  logic [31:0] ir_q, mar_q;

  int passed = 0;
  int total  = 0;
  exp_t sb[$];

  alu_ir_mar_datapath #(.WIDTH(32)) dut (
    .CLK(clk), .CLR(clr), .a(a), .b(b), .op(op), .cin(cin),
    .ir_ld(ir_ld), .ir_d(ir_d), .mar_ld(mar_ld),
    .result(result), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
    .flag_v(flag_v), .ir_q(ir_q), .mar_q(mar_q)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic; C from magnitude comparison or bit 32 of the true sum.
  function automatic exp_t alu_ref(stim_t s);
    exp_t e;
    logic [63:0] aa, bb, ss, nb;
    logic [31:0] r, vx, vy;
    bit arith, c;
    aa = {32'd0, s.a};
    bb = {32'd0, s.b};
    nb = {63'd0, ~s.cin};
    arith = 1'b1;
    c = s.cin;
    vx = s.a;
    vy = s.b;
    r = '0;
    case (s.op)
      5'd2, 5'd10: begin r = s.a - s.b; c = (aa >= bb); vy = ~s.b; end
      5'd3:        begin r = s.b - s.a; c = (bb >= aa); vx = s.b; vy = ~s.a; end
      5'd4, 5'd11: begin ss = aa + bb; r = ss[31:0]; c = ss[32]; end
      5'd5:        begin ss = aa + bb + {63'd0, s.cin}; r = ss[31:0]; c = ss[32]; end
      5'd6:        begin r = 32'(aa - bb - nb); c = (aa >= bb + nb); vy = ~s.b; end
      5'd7:        begin r = 32'(bb - aa - nb); c = (bb >= aa + nb); vx = s.b; vy = ~s.a; end
      5'd16:       begin ss = aa + 64'd4; r = ss[31:0]; c = ss[32]; vy = 32'd4; end
      5'd17:       begin ss = bb + 64'd4; r = ss[31:0]; c = ss[32]; vx = s.b; vy = 32'd4; end
      5'd20:       begin ss = aa + bb + 64'd4; r = ss[31:0]; c = ss[32]; end
      default: begin
        arith = 1'b0;
        case (s.op)
          5'd0, 5'd8:   r = s.a & s.b;
          5'd1, 5'd9:   r = s.a ^ s.b;
          5'd12:        r = s.a | s.b;
          5'd13, 5'd19: r = s.b;
          5'd14:        r = s.a & ~s.b;
          5'd15:        r = ~s.b;
          5'd18:        r = s.a;
          default:      r = '0;
        endcase
      end
    endcase
    e.result = r;
    e.n = r[31];
    e.z = (r == 32'd0);
    e.c = c;
    e.v = arith && (vx[31] == vy[31]) && (r[31] != vx[31]);
    return e;
  endfunction

  function automatic stim_t mk(logic c_clr, logic [4:0] c_op, logic [31:0] c_a,
                               logic [31:0] c_b, logic c_cin, logic c_irld,
                               logic [31:0] c_ird, logic c_marld);
    stim_t s;
    s.clr = c_clr; s.op = c_op; s.a = c_a; s.b = c_b; s.cin = c_cin;
    s.ir_ld = c_irld; s.ir_d = c_ird; s.mar_ld = c_marld;
    return s;
  endfunction

  // Model of the register side, advanced once per transaction.
  stim_t       cur;
  logic [31:0] cur_res;
  logic [31:0] m_ir = '0;
  logic [31:0] m_mar = '0;
  int          txn = 0;

  task automatic apply(input stim_t s);
    exp_t e;
    @(posedge clk);
    if (cur.clr) begin
      m_ir = '0; m_mar = '0;
    end else begin
      if (cur.ir_ld)  m_ir  = cur.ir_d;
      if (cur.mar_ld) m_mar = cur_res;
    end
    #1;
    clr = s.clr; op = s.op; a = s.a; b = s.b; cin = s.cin;
    ir_ld = s.ir_ld; ir_d = s.ir_d; mar_ld = s.mar_ld;
    if (s.clr) begin
      m_ir = '0; m_mar = '0;
    end
    e = alu_ref(s);
    cur = s;
    cur_res = e.result;
    e.ir = m_ir;
    e.mar = m_mar;
    e.id = txn;
    txn++;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input int id, input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s txn %0d: got %08h expected %08h", name, id, got, want);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("result", e.id, result, e.result);
        check("flag_z", e.id, {31'd0, flag_z}, {31'd0, e.z});
        check("flag_n", e.id, {31'd0, flag_n}, {31'd0, e.n});
        check("flag_c", e.id, {31'd0, flag_c}, {31'd0, e.c});
        check("flag_v", e.id, {31'd0, flag_v}, {31'd0, e.v});
        check("ir_q",   e.id, ir_q, e.ir);
        check("mar_q",  e.id, mar_q, e.mar);
        $display("txn %0d: op=%05b a=%08h b=%08h cin=%0b -> result=%08h nzcv=%0b%0b%0b%0b ir=%08h mar=%08h",
                 e.id, op, a, b, cin, result, flag_n, flag_z, flag_c, flag_v, ir_q, mar_q);
      end
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin : driver
    stim_t s;
    int wait_cycles;
    cur = mk(1'b1, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    cur_res = '0;
    // Reset holds across edges despite both loads asserted, then releases.
    apply(mk(1'b1, 5'b00100, 32'd1, 32'd2, 1'b0, 1'b1, 32'hE3A05005, 1'b1));
    apply(mk(1'b1, 5'b00100, 32'd1, 32'd2, 1'b0, 1'b1, 32'hE3A05005, 1'b1));
    apply(mk(1'b0, 5'b00100, 32'd1, 32'd2, 1'b0, 1'b1, 32'hE3A05005, 1'b0));
    apply(mk(1'b0, 5'b00100, 32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, 32'd0, 1'b0));
    apply(mk(1'b0, 5'b00100, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 32'd0, 1'b0));
    apply(mk(1'b0, 5'b01010, 32'd5, 32'd5, 1'b0, 1'b0, 32'd0, 1'b0));
    apply(mk(1'b0, 5'b00010, 32'd3, 32'd5, 1'b0, 1'b0, 32'd0, 1'b0));
    apply(mk(1'b0, 5'b00101, 32'd1, 32'd1, 1'b1, 1'b0, 32'd0, 1'b0));
    apply(mk(1'b0, 5'b00110, 32'd1, 32'd1, 1'b0, 1'b0, 32'd0, 1'b0));
    apply(mk(1'b0, 5'b01110, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 1'b0, 32'd0, 1'b0));
    apply(mk(1'b0, 5'b01111, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 1'b0, 32'd0, 1'b0));
    apply(mk(1'b0, 5'b10000, 32'h100, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1));
    apply(mk(1'b0, 5'b10000, 32'h200, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0));
    apply(mk(1'b0, 5'b10100, 32'h200, 32'h10, 1'b0, 1'b1, 32'h12345678, 1'b1));
    apply(mk(1'b0, 5'b10111, 32'h200, 32'h10, 1'b1, 1'b0, 32'd0, 1'b0));
    // Mid-cycle reset clears at once; release resumes loading on the next edge.
    apply(mk(1'b1, 5'b10011, 32'h1, 32'hABCD, 1'b0, 1'b1, 32'hCAFEF00D, 1'b1));
    apply(mk(1'b0, 5'b10011, 32'h1, 32'hABCD, 1'b0, 1'b1, 32'hCAFEF00D, 1'b1));
    apply(mk(1'b0, 5'b10010, 32'h1, 32'hABCD, 1'b0, 1'b0, 32'h0, 1'b0));
    for (int i = 0; i < 400; i++) begin
      s.clr    = ($urandom_range(0, 19) == 0);
      s.op     = 5'($urandom_range(0, 31));
      s.a      = pick();
      s.b      = pick();
      s.cin    = 1'($urandom_range(0, 1));
      s.ir_ld  = 1'($urandom_range(0, 1));
      s.ir_d   = $urandom;
      s.mar_ld = 1'($urandom_range(0, 1));
      apply(s);
    end
    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (sb.size() > 0) begin
      total++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "timeout");
  end

endmodule
